// File: rtl/div_sched_pkg.sv
// Shared types and helpers for the round-robin divider scheduler.
package div_sched_pkg;

  localparam int DEF_N_REQ = 2;
  localparam int DEF_WIDTH = 8;
  localparam int MAX_REQ   = 8;
  localparam int PICK_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic              any;
    logic [PICK_W-1:0] idx;
  } rr_pick_t;

  // First valid requester at or above ptr, wrapping at n_req.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input int unsigned ptr,
                                       input int unsigned n_req);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = ptr + k;
      if (cand >= n_req) cand = cand - n_req;
      if ((k < n_req) && !res.any && valid[cand[PICK_W-1:0]]) begin
        res.any = 1'b1;
        res.idx = cand[PICK_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/div_core.sv
// Iterative radix-2 restoring divider: one quotient bit per step.
module div_core
  import div_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic [WIDTH-1:0] o_part_dvd,
  output logic [WIDTH-1:0] o_part_dsr
);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    trial = {rem_q, dvd_q[WIDTH-1]};
    fits  = trial >= {1'b0, dsr_q};
    // When fits is set the true difference is below 2^WIDTH, so the low bits suffice.
    diff  = trial[WIDTH-1:0] - dsr_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvd_d = dvd_q;
    dsr_d = dsr_q;
    if (i_start) begin
      dsr_d = i_divisor;
      if (i_divisor == '0) begin
        quo_d = '1;
        rem_d = i_dividend;
        dvd_d = '0;
      end else begin
        quo_d = '0;
        rem_d = '0;
        dvd_d = i_dividend;
      end
    end else if (i_step) begin
      dvd_d = dvd_q << 1;
      quo_d = {quo_q[WIDTH-2:0], fits};
      rem_d = fits ? diff : trial[WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvd_q <= '0;
      dsr_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      dsr_q <= dsr_d;
    end
  end

  assign o_quotient  = quo_q;
  assign o_remainder = rem_q;
  assign o_part_dvd  = dvd_q;
  assign o_part_dsr  = dsr_q;

endmodule

// File: rtl/div_scheduler.sv
// Round-robin arbiter and sequencer sharing one div_core among N_REQ requesters.
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [N_REQ-1:0]       i_req_valid,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic [N_REQ*WIDTH-1:0] i_dividend,
  input  logic [N_REQ*WIDTH-1:0] i_divisor,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [ID_W-1:0]        o_rsp_id,
  output logic [WIDTH-1:0]       o_quotient,
  output logic [WIDTH-1:0]       o_remainder,
  output logic                   o_div_by_zero,
  output logic                   o_busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               dbz_q, dbz_d;
  logic               rsp_valid_q;
  logic               busy_q;

  logic [MAX_REQ-1:0] vld_ext;
  rr_pick_t           pick;
  logic [ID_W-1:0]    gnt;
  logic [ID_W-1:0]    gnt_next;
  logic [WIDTH-1:0]   sel_dividend;
  logic [WIDTH-1:0]   sel_divisor;
  logic               accept;
  logic               core_start;
  logic               core_step;
  logic [WIDTH-1:0]   part_dvd;
  logic [WIDTH-1:0]   part_dsr;
  logic               unused_bits;

  always_comb begin
    vld_ext                = '0;
    vld_ext[N_REQ-1:0]     = i_req_valid;
    pick                   = rr_pick(vld_ext, 32'(rr_ptr_q), N_REQ);
    gnt                    = ID_W'(pick.idx);
    gnt_next               = (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + ID_W'(1);
    sel_dividend           = i_dividend[gnt*WIDTH +: WIDTH];
    sel_divisor            = i_divisor[gnt*WIDTH +: WIDTH];
    accept                 = (state_q == ST_IDLE) && pick.any;
  end

  // Ready is forced low while reset is asserted so every output reads zero.
  always_comb begin
    o_req_ready = '0;
    if (accept && i_reset_n) o_req_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    dbz_d      = dbz_q;
    core_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          core_start = 1'b1;
          id_d       = gnt;
          rr_ptr_d   = gnt_next;
          dbz_d      = (sel_divisor == '0);
          cnt_d      = '0;
          state_d    = (sel_divisor == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    core_step = (state_q == ST_RUN);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      dbz_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      dbz_q       <= dbz_d;
      rsp_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  div_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_start    (core_start),
    .i_dividend (sel_dividend),
    .i_divisor  (sel_divisor),
    .i_step     (core_step),
    .o_quotient (o_quotient),
    .o_remainder(o_remainder),
    .o_part_dvd (part_dvd),
    .o_part_dsr (part_dsr)
  );

  assign unused_bits   = ^{part_dvd, part_dsr, pick};

  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_id      = id_q;
  assign o_div_by_zero = dbz_q;
  assign o_busy        = busy_q;

endmodule
